// File: rtl/mont_csa_resolver.sv
// mont_csa_resolver
//   Consumer end of the Montgomery carry-save adder array. It takes the final
//   redundant (sum, carry) pair and resolves it to a canonical residue:
//     T = (sum >> 1) + carry
//     D = T - MODULUS
//     result = (T >= MODULUS) ? D : T
//   T and D are built one LIMB_WIDTH-bit limb per cycle by a limb-serial
//   carry-propagate adder. A borrow chain runs beside it in the same cycle, so
//   the final borrow decides which value is selected.
//
// Ports
//   clk_i    : clock
//   rst_i    : synchronous reset, active-high
//   valid_i  : sum_i/carry_i valid
//   ready_o  : resolver can accept an operand pair (IDLE only)
//   sum_i    : [DATA_WIDTH:0] carry-save sum vector (bit 0 ignored, always 0)
//   carry_i  : [DATA_WIDTH:0] carry-save carry vector
//   valid_o  : res_o/ovf_o valid (DONE)
//   ready_i  : downstream accepts res_o
//   res_o    : [DATA_WIDTH-1:0] resolved, conditionally reduced result
//   ovf_o    : selected value had bits at or above DATA_WIDTH set
module mont_csa_resolver #(
  parameter int unsigned           DATA_WIDTH = 255,
  parameter int unsigned           LIMB_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] MODULUS    =
    255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH:0]   sum_i,
  input  logic [DATA_WIDTH:0]   carry_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  ovf_o
);

  localparam int unsigned T_WIDTH = DATA_WIDTH + 2;
  localparam int unsigned NL      = (T_WIDTH + LIMB_WIDTH - 1) / LIMB_WIDTH;
  localparam int unsigned PW      = NL * LIMB_WIDTH;
  localparam int unsigned CW      = (NL > 1) ? $clog2(NL) : 1;

  // Modulus padded to whole limbs; the pad bits are zero.
  localparam logic [PW-1:0] M_PAD = PW'(MODULUS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    c_q;
  logic                    bor_q;
  logic                    ready_q;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   res_q;
  logic                    ovf_q;

  // Operand and result shift registers. Operands shift out at the bottom, and
  // result limbs shift in at the top. After NL limbs everything is aligned.
  logic [PW-1:0]           opa_q;
  logic [PW-1:0]           opb_q;
  logic [PW-1:0]           t_q;
  logic [PW-1:0]           d_q;

  logic [LIMB_WIDTH-1:0]   m_limb;
  logic [LIMB_WIDTH:0]     tsum;
  logic [LIMB_WIDTH:0]     dsub;
  logic [PW-1:0]           t_d;
  logic [PW-1:0]           d_d;
  logic [PW-1:0]           sel;
  logic [DATA_WIDTH-1:0]   res_d;
  logic                    ovf_d;
  logic                    accept;

  assign accept = (state_q == IDLE) && valid_i && ready_q;

  // Limb datapath: the add and the subtract are chained in the same cycle.
  always_comb begin
    m_limb = M_PAD[cnt_q*LIMB_WIDTH +: LIMB_WIDTH];
    tsum   = {1'b0, opa_q[LIMB_WIDTH-1:0]} + {1'b0, opb_q[LIMB_WIDTH-1:0]}
           + {{LIMB_WIDTH{1'b0}}, c_q};
    dsub   = {1'b0, tsum[LIMB_WIDTH-1:0]} - {1'b0, m_limb}
           - {{LIMB_WIDTH{1'b0}}, bor_q};
    t_d    = {tsum[LIMB_WIDTH-1:0], t_q[PW-1:LIMB_WIDTH]};
    d_d    = {dsub[LIMB_WIDTH-1:0], d_q[PW-1:LIMB_WIDTH]};
    // On the last limb, a clear final borrow means T >= MODULUS.
    sel    = dsub[LIMB_WIDTH] ? t_d : d_d;
    res_d  = sel[DATA_WIDTH-1:0];
    ovf_d  = |sel[T_WIDTH-1:DATA_WIDTH];
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      bor_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RUN;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            bor_q   <= 1'b0;
          end
        end
        RUN: begin
          c_q   <= tsum[LIMB_WIDTH];
          bor_q <= dsub[LIMB_WIDTH];
          if (cnt_q == CW'(NL - 1)) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Operand capture / limb shifting. Data only, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      opa_q <= PW'({1'b0, sum_i[DATA_WIDTH:1]});
      opb_q <= PW'(carry_i);
    end else if (state_q == RUN) begin
      opa_q <= opa_q >> LIMB_WIDTH;
      opb_q <= opb_q >> LIMB_WIDTH;
      t_q   <= t_d;
      d_q   <= d_d;
    end
  end

  // sum_i[0] is always zero from the array. The bottom result limbs are
  // shifted out, and the pad bits never reach the outputs.
  logic unused_bits;
  assign unused_bits = ^{sum_i[0], t_q[LIMB_WIDTH-1:0], d_q[LIMB_WIDTH-1:0],
                         sel[PW-1:T_WIDTH]};

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign res_o   = res_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_mont_csa_resolver.sv
module tb_mont_csa_resolver;

  localparam logic [254:0] M =
    255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
  localparam int NL = 5;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [255:0] sum_i;
  logic [255:0] carry_i;
  logic         valid_o;
  logic         ready_i;
  logic [254:0] res_o;
  logic         ovf_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mont_csa_resolver dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sum_i   (sum_i),
    .carry_i (carry_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .res_o   (res_o),
    .ovf_o   (ovf_o)
  );

  typedef struct {
    logic [255:0] s;
    logic [255:0] c;
    logic [254:0] r;
    logic         o;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [256:0] act, input logic [256:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one operand pair for a single accepting edge.
  task automatic accept_op(input logic [255:0] s, input logic [255:0] c);
    @(negedge clk);
    chk("ready_before_accept", 257'(ready_o), 257'd1);
    sum_i   = s;
    carry_i = c;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  // Cycles from the accepting edge to valid_o, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_o && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release_out;
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_drop", 257'(valid_o), 257'd0);
    chk("ready_back", 257'(ready_o), 257'd1);
    ready_i = 1'b0;
  endtask

  task automatic run_vec(input string nm, input logic [255:0] s, input logic [255:0] c,
                         input logic [254:0] r, input logic o);
    int lat;
    accept_op(s, c);
    wait_valid(lat);
    chk({nm, "_latency"}, 257'(lat), 257'(NL));
    chk({nm, "_res"}, 257'(res_o), 257'(r));
    chk({nm, "_ovf"}, 257'(ovf_o), 257'(o));
    release_out();
  endtask

  initial begin
    logic [255:0] rs, rc, t;
    logic [254:0] x;
    int           lat;
    bit           seen;

    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    sum_i   = '0;
    carry_i = '0;

    vt[0] = '{s: 256'd0,              c: 256'd5,            r: 255'd5,          o: 1'b0};
    vt[1] = '{s: {M, 1'b0},           c: 256'd0,            r: 255'd0,          o: 1'b0};
    vt[2] = '{s: 256'd2,              c: {1'b0, M},         r: 255'd1,          o: 1'b0};
    vt[3] = '{s: 256'd0,              c: {1'b0, M - 1'b1},  r: M - 255'd1,      o: 1'b0};
    vt[4] = '{s: (256'd1 << 193) - 256'd2, c: 256'd1,       r: 255'd1 << 192,   o: 1'b0};
    vt[5] = '{s: {M - 255'd1, 1'b0},  c: {1'b0, M - 1'b1},  r: M - 255'd2,      o: 1'b0};
    vt[6] = '{s: {M, 1'b0},           c: {1'b0, M - 1'b1},  r: M - 255'd1,      o: 1'b0};
    vt[7] = '{s: 256'd0,              c: {1'b1, M},         r: 255'd0,          o: 1'b1};

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("reset_ready", 257'(ready_o), 257'd1);
    chk("reset_valid", 257'(valid_o), 257'd0);
    chk("reset_res",   257'(res_o),   257'd0);
    chk("reset_ovf",   257'(ovf_o),   257'd0);

    for (int i = 0; i < 8; i++)
      run_vec($sformatf("vec%0d", i), vt[i].s, vt[i].c, vt[i].r, vt[i].o);

    // Random T < 2M against T mod M.
    for (int i = 0; i < 6; i++) begin
      x  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      x[254] = 1'b0;
      rs = {x, 1'b0};
      rc = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rc[255:254] = 2'b00;
      t  = {1'b0, rs[255:1]} + rc;
      if (t >= {1'b0, M}) t = t - {1'b0, M};
      run_vec($sformatf("rand%0d", i), rs, rc, t[254:0], 1'b0);
    end

    // Back-pressure, plus a valid_i pulse during RUN that must be ignored.
    accept_op(256'd0, 256'd9);
    @(negedge clk);
    sum_i   = 256'd0;
    carry_i = 256'd3;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    wait_valid(lat);
    chk("bp_valid", 257'(valid_o), 257'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold_res%0d", i), 257'(res_o), 257'd9);
      chk($sformatf("bp_hold_rdy%0d", i), 257'({valid_o, ready_o}), 257'b10);
    end
    release_out();
    seen = 1'b0;
    repeat (NL + 2) begin
      @(posedge clk);
      #1 if (valid_o) seen = 1'b1;
    end
    chk("bp_no_ghost", 257'(seen), 257'd0);

    // Reset during RUN cycle 2 drops the operation.
    accept_op(256'd0, 256'd11);
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    chk("rst_run_ready", 257'(ready_o), 257'd1);
    seen = 1'b0;
    repeat (NL + 3) begin
      @(posedge clk);
      #1 if (valid_o) seen = 1'b1;
    end
    chk("rst_run_no_valid", 257'(seen), 257'd0);
    run_vec("after_rst", 256'd0, 256'd7, 255'd7, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
